// File: rtl/ram_req_responder.sv
// Block-RAM stand-in for the PSRAM controller request port: two byte-wide banks
// served with the same CE/busy/dataReady handshake and a fixed per-access latency.
module ram_req_responder #(
  parameter int ADDR_BITS   = 12,
  parameter int LATENCY     = 3,
  parameter int INIT_CYCLES = 16
) (
  input  logic        clkSys,
  input  logic        rst,
  input  logic        i_cs,
  input  logic        i_write,
  input  logic [23:0] i_address,
  input  logic        i_bank,
  input  logic [7:0]  i_dataToWrite,
  output logic [7:0]  o_dataRead,
  output logic        o_busy,
  output logic        o_dataReady,
  output logic        o_error,
  output logic [2:0]  o_state
);

  localparam int          DEPTH     = 1 << ADDR_BITS;
  localparam logic [15:0] INIT_LOAD = 16'(INIT_CYCLES - 1);
  localparam logic [15:0] LAT_LOAD  = 16'(LATENCY - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                 state_reg, state_next;
  logic [15:0]            cnt_reg, cnt_next;
  logic                   req_write_reg, req_write_next;
  logic                   req_bank_reg, req_bank_next;
  logic [ADDR_BITS-1:0]   req_addr_reg, req_addr_next;
  logic [7:0]             req_data_reg, req_data_next;
  logic                   req_oor_reg, req_oor_next;
  logic [7:0]             data_read_reg, data_read_next;
  logic                   data_ready_reg, data_ready_next;
  logic                   error_reg, error_next;

  logic                   addr_oor;
  logic                   wr_commit;
  logic                   rd_issue;
  logic [7:0]             rd_sel;

  // Any address bit above the bank size makes the access out of range.
  assign addr_oor  = |(i_address >> ADDR_BITS);
  assign wr_commit = (state_reg == ST_WRITE) && (cnt_reg == 16'd0) && !req_oor_reg;
  assign rd_issue  = (state_reg == ST_READ) && (cnt_reg == 16'd0);

  always_ff @(posedge clkSys or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_INIT;
      cnt_reg        <= INIT_LOAD;
      req_write_reg  <= 1'b0;
      req_bank_reg   <= 1'b0;
      req_addr_reg   <= '0;
      req_data_reg   <= 8'h00;
      req_oor_reg    <= 1'b0;
      data_read_reg  <= 8'h00;
      data_ready_reg <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      req_write_reg  <= req_write_next;
      req_bank_reg   <= req_bank_next;
      req_addr_reg   <= req_addr_next;
      req_data_reg   <= req_data_next;
      req_oor_reg    <= req_oor_next;
      data_read_reg  <= data_read_next;
      data_ready_reg <= data_ready_next;
      error_reg      <= error_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    req_write_next  = req_write_reg;
    req_bank_next   = req_bank_reg;
    req_addr_next   = req_addr_reg;
    req_data_next   = req_data_reg;
    req_oor_next    = req_oor_reg;
    data_read_next  = data_read_reg;
    data_ready_next = 1'b0;
    error_next      = 1'b0;

    case (state_reg)
      ST_INIT: begin
        if (cnt_reg == 16'd0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end
      ST_IDLE: begin
        if (!i_cs) begin
          state_next     = i_write ? ST_WRITE : ST_READ;
          cnt_next       = LAT_LOAD;
          req_write_next = i_write;
          req_bank_next  = i_bank;
          req_addr_next  = i_address[ADDR_BITS-1:0];
          req_data_next  = i_dataToWrite;
          req_oor_next   = addr_oor;
        end
      end
      ST_WRITE, ST_READ: begin
        if (cnt_reg == 16'd0) begin
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        error_next = req_oor_reg;
        if (!req_write_reg) begin
          data_ready_next = 1'b1;
          data_read_next  = req_oor_reg ? 8'hFF : rd_sel;
        end
      end
      default: begin
        state_next = ST_INIT;
        cnt_next   = INIT_LOAD;
      end
    endcase
  end

  // Storage is never reset so each bank maps onto a plain block RAM.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_data;

    always_ff @(posedge clkSys) begin
      if (wr_commit && (req_bank_reg == 1'(gi))) begin
        mem[req_addr_reg] <= req_data_reg;
      end
      if (rd_issue) begin
        rd_data <= mem[req_addr_reg];
      end
    end
  end

  assign rd_sel      = req_bank_reg ? g_bank[1].rd_data : g_bank[0].rd_data;
  assign o_dataRead  = data_read_reg;
  assign o_busy      = (state_reg != ST_IDLE);
  assign o_dataReady = data_ready_reg;
  assign o_error     = error_reg;
  assign o_state     = state_reg;

endmodule

// File: tb/tb_ram_req_responder.sv
// Directed + randomized checks of ram_req_responder against a byte-array model
// with timing expectations derived from LATENCY and INIT_CYCLES.
module tb_ram_req_responder;

  localparam int ADDR_BITS   = 12;
  localparam int LATENCY     = 3;
  localparam int INIT_CYCLES = 16;

  logic        clkSys = 1'b0;
  logic        rst;
  logic        i_cs;
  logic        i_write;
  logic [23:0] i_address;
  logic        i_bank;
  logic [7:0]  i_dataToWrite;
  logic [7:0]  o_dataRead;
  logic        o_busy;
  logic        o_dataReady;
  logic        o_error;
  logic [2:0]  o_state;

  int total = 0;
  int bad   = 0;

  logic [7:0] model_mem   [2][4096];
  bit         model_valid [2][4096];
  logic [7:0] last_read;

  always #5 clkSys = ~clkSys;

  ram_req_responder #(
    .ADDR_BITS  (ADDR_BITS),
    .LATENCY    (LATENCY),
    .INIT_CYCLES(INIT_CYCLES)
  ) dut (
    .clkSys       (clkSys),
    .rst          (rst),
    .i_cs         (i_cs),
    .i_write      (i_write),
    .i_address    (i_address),
    .i_bank       (i_bank),
    .i_dataToWrite(i_dataToWrite),
    .o_dataRead   (o_dataRead),
    .o_busy       (o_busy),
    .o_dataReady  (o_dataReady),
    .o_error      (o_error),
    .o_state      (o_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkSys);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("idle_timeout", {31'd0, o_busy}, 32'd0);
  endtask

  task automatic junk_inputs(input bit hold_cs);
    i_cs          = hold_cs ? 1'b0 : 1'b1;
    i_write       = 1'($urandom);
    i_address     = 24'($urandom);
    i_bank        = 1'($urandom);
    i_dataToWrite = 8'($urandom);
  endtask

  // Counts edges spent busy after reset release; every one must be in Init.
  task automatic check_init(input string tag);
    int n;
    n = 0;
    while (o_busy === 1'b1 && n < 100) begin
      chk({tag, "_state"}, {29'd0, o_state}, 32'd1);
      tick();
      n++;
    end
    chk({tag, "_len"}, n, INIT_CYCLES);
  endtask

  // One access; offset k counts edges after the accepting edge.
  task automatic xfer(input bit wr, input logic [23:0] addr, input bit bank,
                      input logic [7:0] d, input bit b2b);
    bit         oor;
    logic [7:0] exp_rd;
    logic [11:0] a;
    int         exp_state;
    a      = addr[11:0];
    oor    = (addr[23:12] != 12'd0);
    exp_rd = last_read;
    if (!b2b) wait_idle();
    i_cs          = 1'b0;
    i_write       = wr;
    i_address     = addr;
    i_bank        = bank;
    i_dataToWrite = d;
    tick();
    if (wr && !oor) begin
      model_mem[bank][a]   = d;
      model_valid[bank][a] = 1'b1;
    end
    if (!wr) exp_rd = oor ? 8'hFF : model_mem[bank][a];
    for (int k = 0; k <= LATENCY + 1; k++) begin
      exp_state = (k < LATENCY) ? (wr ? 2 : 3) : ((k == LATENCY) ? 4 : 0);
      chk($sformatf("state_k%0d", k), {29'd0, o_state}, exp_state);
      chk($sformatf("busy_k%0d", k), {31'd0, o_busy}, (k <= LATENCY) ? 1 : 0);
      chk($sformatf("ready_k%0d", k), {31'd0, o_dataReady},
          (k == LATENCY + 1 && !wr) ? 1 : 0);
      chk($sformatf("error_k%0d", k), {31'd0, o_error},
          (k == LATENCY + 1 && oor) ? 1 : 0);
      if (k == LATENCY + 1) begin
        chk("data_read", {24'd0, o_dataRead}, {24'd0, exp_rd});
      end else begin
        junk_inputs(b2b);
        tick();
      end
    end
    last_read = exp_rd;
    if (!b2b) begin
      tick();
      chk("ready_clear", {31'd0, o_dataReady}, 32'd0);
      chk("error_clear", {31'd0, o_error}, 32'd0);
    end
    $display("xfer %s bank=%0d addr=%06h wdata=%02h dout=%02h oor=%0d b2b=%0d",
             wr ? "WR" : "RD", bank, addr, d, o_dataRead, oor, b2b);
  endtask

  initial begin
    logic [23:0] addr;
    bit          wr;
    bit          bank;
    int          n;

    rst = 1'b0;
    i_cs = 1'b0; i_write = 1'b1; i_address = 24'h0; i_bank = 1'b0; i_dataToWrite = 8'h5A;
    last_read = 8'h00;
    tick();
    tick();
    chk("rst_state", {29'd0, o_state}, 32'd1);
    chk("rst_busy", {31'd0, o_busy}, 32'd1);
    chk("rst_ready", {31'd0, o_dataReady}, 32'd0);
    chk("rst_error", {31'd0, o_error}, 32'd0);
    chk("rst_dout", {24'd0, o_dataRead}, 32'd0);

    // Release with a write request held; it must not be taken during Init.
    rst = 1'b1;
    check_init("init");
    i_cs = 1'b1;
    chk("init_idle_state", {29'd0, o_state}, 32'd0);
    tick();
    chk("init_not_queued", {29'd0, o_state}, 32'd0);
    $display("init done after %0d busy cycles", INIT_CYCLES);

    xfer(1'b1, 24'h000002, 1'b0, 8'hCA, 1'b0);
    xfer(1'b0, 24'h000002, 1'b0, 8'h00, 1'b0);

    xfer(1'b1, 24'h000005, 1'b0, 8'h11, 1'b0);
    xfer(1'b1, 24'h000005, 1'b1, 8'h22, 1'b0);
    xfer(1'b0, 24'h000005, 1'b0, 8'h00, 1'b0);
    xfer(1'b0, 24'h000005, 1'b1, 8'h00, 1'b0);

    xfer(1'b0, 24'h001000, 1'b0, 8'h00, 1'b0);
    xfer(1'b1, 24'h000000, 1'b0, 8'h3C, 1'b0);
    xfer(1'b1, 24'h001000, 1'b0, 8'h77, 1'b0);
    xfer(1'b0, 24'h000000, 1'b0, 8'h00, 1'b0);
    xfer(1'b0, 24'h800005, 1'b1, 8'h00, 1'b0);

    // i_cs held low: accepts must land exactly LATENCY+2 edges apart.
    wait_idle();
    for (int j = 0; j < 16; j++) begin
      xfer(j < 8, 24'h000020 + 24'(j % 8), 1'b0, 8'($urandom), 1'b1);
    end
    i_cs = 1'b1;
    tick();
    chk("b2b_end_ready", {31'd0, o_dataReady}, 32'd0);
    chk("b2b_end_state", {29'd0, o_state}, 32'd0);

    for (int j = 0; j < 30; j++) begin
      bank = 1'($urandom);
      addr = 24'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) addr[23:12] = 12'($urandom_range(1, 4095));
      wr = 1'($urandom);
      if (!wr && addr[23:12] == 12'd0 && !model_valid[bank][addr[11:0]]) wr = 1'b1;
      xfer(wr, addr, bank, 8'($urandom), 1'b0);
    end

    // Reset two edges into a read: no completion pulse, back to Init.
    xfer(1'b1, 24'h000009, 1'b1, 8'h5E, 1'b0);
    wait_idle();
    i_cs = 1'b0; i_write = 1'b0; i_address = 24'h000009; i_bank = 1'b1;
    tick();
    i_cs = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_state", {29'd0, o_state}, 32'd1);
    chk("mid_rst_busy", {31'd0, o_busy}, 32'd1);
    n = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (o_dataReady !== 1'b0 || o_error !== 1'b0) n++;
    end
    chk("mid_rst_no_pulse", n, 0);
    last_read = 8'h00;
    rst = 1'b1;
    n = 0;
    check_init("reinit");
    chk("reinit_no_pulse", {31'd0, o_dataReady}, 32'd0);
    $display("reset mid-read recovered");
    xfer(1'b0, 24'h000009, 1'b1, 8'h00, 1'b0);
    xfer(1'b0, 24'h000002, 1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_req_responder.md
# ram_req_responder

On-chip block-RAM responder for the memory-controller request port (CE / write / address / bank / busy / dataReady) driven by the gm64 top-level sequencer. It serves the same handshake as the PSRAM controller from internal storage, so the sequencer and later CPU/VIC bus logic can be brought up and regression-tested without external PSRAM. It sits in the clkSys domain, in place of the PSRAM controller instance.

## Interface
- ADDR_BITS, 12: byte storage per bank = 2^ADDR_BITS; address bits [23:ADDR_BITS] must be zero.
- LATENCY, 3: wait cycles per access (legal range 1..15).
- INIT_CYCLES, 16: power-up busy period after reset release (legal range 1..65535).
- clkSys  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_cs  in  1  request strobe, active-low, sampled per cycle.
- i_write  in  1  1 = write, 0 = read; sampled with i_cs.
- i_address  in  24  byte address; sampled with i_cs.
- i_bank  in  1  bank select; sampled with i_cs.
- i_dataToWrite  in  8  write data; sampled with i_cs.
- o_dataRead  out  8  last read data; held until next read completes.
- o_busy  out  1  1 = request will not be accepted.
- o_dataReady  out  1  one-cycle pulse, read data valid.
- o_error  out  1  one-cycle pulse, out-of-range access completed.
- o_state  out  3  Idle=0, Init=1, Write=2, Read=3, Done=4.

## Operation
- Storage: two banks × 2^ADDR_BITS bytes, inferred block RAM, not cleared by reset.
- Reset (rst=0): o_state=Init, o_busy=1, o_dataReady=0, o_error=0, o_dataRead=8'h00, wait counter=INIT_CYCLES-1, latched request cleared.
- Init: counter decrements each cycle; at 0 -> Idle, o_busy=0. i_cs ignored (not queued) throughout Init.
- Idle: i_cs=0 at an edge with o_busy=0 accepts; write, address, bank, data latched; -> Write or Read; o_busy=1; counter=LATENCY-1. i_cs=1: remain Idle.
- Write/Read: counter decrements; at 0 -> Done. Write: RAM written at the edge leaving Write. Read: RAM read issued at the edge leaving Read.
- Done: single cycle; -> Idle at next edge with o_busy=0; for reads o_dataRead updated and o_dataReady=1 at the same edge.
- Out-of-range (any of i_address[23:ADDR_BITS] nonzero): full latency still taken; write discarded, read returns 8'hFF; o_error pulses alongside Done->Idle transition (with o_dataReady for reads).
- i_cs, i_write, i_address etc. changing while busy: no effect on the in-flight access.
- i_cs held low continuously: new request accepted on every edge where o_busy=0 (back-to-back).

## Timing
- Request sampled at edge T (Idle, o_busy=0, i_cs=0).
- T+1: o_state=Write/Read, o_busy=1.
- T+1+LATENCY: o_state=Done, o_busy=1.
- T+2+LATENCY: o_state=Idle, o_busy=0; read: o_dataReady=1, o_dataRead valid; o_dataReady back to 0 at T+3+LATENCY.
- Back-to-back: next accept earliest at T+2+LATENCY (same edge busy drops is not an accept; first accept edge is the one where sampled o_busy=0).
- Read-after-write to same address returns written data with no extra delay.
- After rst release at edge R0: o_busy falls at R0+INIT_CYCLES.
- Reset mid-access: immediate return to Init; in-flight write not guaranteed committed unless it passed its commit edge; no o_dataReady/o_error pulse.

## Test plan
- Init: release rst, hold i_cs=0 -> o_state=1, o_busy=1 for exactly 16 cycles, no write occurs; then o_busy=0, o_state=0.
- Write/read: write 8'hCA to addr 24'h000002 bank 0, then read it -> o_dataReady single pulse at T+5 with o_dataRead=8'hCA, o_error=0; o_state sequence 0,3,3,3,4,0.
- Bank isolation: write 8'h11 bank 0 addr 5, 8'h22 bank 1 addr 5 -> reads return 8'h11 / 8'h22 respectively.
- Out-of-range: read 24'h001000 (ADDR_BITS=12) -> o_dataRead=8'hFF, o_error and o_dataReady pulse together; write there then read addr 0 -> prior contents of addr 0 unchanged.
- Back-to-back: i_cs=0 held, alternating addresses 0..7 writes then reads -> one accept every LATENCY+2 cycles, all 8 bytes read back correctly, request inputs changed mid-busy ignored.
- Reset mid-read: assert rst at T+2 -> o_dataReady never pulses, o_state=1, o_busy=1; after Init a read of previously written data still returns it.
